prv_trap_ctrl: RTL
==================

Name: prv_trap_ctrl

Overview:
Trap sequencer inside the priv block, directly downstream of the pipeline-to-priv interface.
- Consumes exception, interrupt, protection-fault, pipe_clear and ret signals from the hazard unit.
- Prioritises them, captures cause, epc and tval, and waits for the pipeline to drain.
- Then issues the one-cycle insert_pc/priv_pc redirect and the machine CSR update strobes.
- Also sequences mret redirects.

Parameters:
NUM_EXTENSIONS, 1, number of RISC-MGMT extensions; ex_rmgmt_cause width is max(1,$clog2(NUM_EXTENSIONS))
SYNC_STAGES, 2, flop count of the ext_int synchroniser (minimum 2)

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env_m  in  1 each  exception flags from hazard unit
prot_fault_i, prot_fault_l, prot_fault_s  in  1 each  PMP/PMA faults
ex_rmgmt  in  1  RISC-MGMT exception
ex_rmgmt_cause  in  max(1,$clog2(NUM_EXTENSIONS))  extension index
epc, badaddr  in  32  faulting PC, faulting address
pipe_clear  in  1  pipeline drained
ret  in  1  mret retiring
timer_int, soft_int  in  1  internal level interrupts
ext_int  in  1  asynchronous external interrupt
mstatus_mie  in  1  global interrupt enable
mie_meie, mie_msie, mie_mtie  in  1  per-source enables
mtvec, mepc_r  in  32  current CSR values
insert_pc  out  1  redirect strobe
priv_pc  out  32  redirect target
intr  out  1  interrupt trap in progress
csr_trap_we  out  1  write mcause/mepc/mtval
mcause_d  out  32  {interrupt bit, 26'b0, 5-bit code}
mepc_d, mtval_d  out  32  values to write
mret_we  out  1  restore mstatus on mret

Behaviour:
- Reset: state IDLE; all outputs 0; synchroniser flops and capture registers 0. Reset mid-sequence discards the pending trap.
- ext_int passes through SYNC_STAGES flops; timer_int and soft_int are used directly.
- exc_any is the OR of all exception and protection flags.
- int_pend = mstatus_mie & ((ext_s & mie_meie) | (soft_int & mie_msie) | (timer_int & mie_mtie)).
- Exception priority, highest first, with mcause code:
  - fault_insn | prot_fault_i → 1
  - illegal_insn → 2
  - mal_insn → 0
  - env_m → 11
  - breakpoint → 3
  - mal_s → 6
  - mal_l → 4
  - fault_s | prot_fault_s → 7
  - fault_l | prot_fault_l → 5
  - ex_rmgmt → 24 + ex_rmgmt_cause
- Interrupt priority, highest first: ext (11) > soft (3) > timer (7).
- A simultaneous exception beats an interrupt.
- FSM states: IDLE, WAIT_CLEAR, COMMIT, RET.
- IDLE:
  - exc_any | int_pend: capture cause, is_int, epc, and tval; go to WAIT_CLEAR.
  - tval = badaddr for cause codes 0, 1, 4, 5, 6, 7; otherwise 0.
  - Else ret: go to RET. ret in the same cycle as a trap is dropped.
- WAIT_CLEAR:
  - intr = is_int.
  - New exceptions and interrupts are ignored; the first capture wins.
  - pipe_clear=1 goes to COMMIT next cycle.
- COMMIT, exactly one cycle:
  - insert_pc=1, csr_trap_we=1, intr=is_int.
  - mcause_d = {is_int, 26'b0, code}; mepc_d = captured epc; mtval_d = captured tval.
  - Go to IDLE.
- RET, exactly one cycle: insert_pc=1, priv_pc=mepc_r, mret_we=1; go to IDLE.
- Trap target:
  - base = {mtvec[31:2], 2'b00}.
  - If mtvec[1:0]==2'b01 and is_int: priv_pc = base + (code << 2), 32-bit wrap.
  - Otherwise priv_pc = base. Modes 2 and 3 are treated as direct.
- Latency:
  - Trap detection to insert_pc is 2 cycles when pipe_clear is already 1; otherwise 1 cycle after pipe_clear.
  - ret to insert_pc is 1 cycle.
- Outputs are registered; priv_pc is valid only while insert_pc=1, and 0 otherwise.

Decomposition:
- machine_mode_types_1_12_pkg holds:
  - ex_code_t and int_code_t enums (codes above);
  - mtvec mode constants (DIRECT=2'b00, VECTORED=2'b01);
  - trap FSM state enum trap_state_t.
- One combinational sub-module, prv_trap_prio_enc:
  - inputs: flags, int_pend sources, ex_rmgmt_cause;
  - outputs: code[4:0], is_int, tval_sel.

Test Plan:
- Exceptions vs pipe_clear:
  - illegal_insn=1 and mal_l=1, epc=0x100, badaddr=0xDEAD, pipe_clear=1 → 2 cycles later insert_pc=1, mcause_d=2, mepc_d=0x100, mtval_d=0, priv_pc=mtvec base.
  - mal_l alone, pipe_clear held 0 for 5 cycles → no insert_pc until 1 cycle after pipe_clear rises; mcause_d=4, mtval_d=0xDEAD.
- Vectored interrupt priority: mtvec=0x8001, mstatus_mie=1, all enables=1; timer_int and soft_int raised together → intr=1, mcause_d=0x80000003, priv_pc=0x800C.
- ext_int synchroniser and exception-beats-interrupt:
  - ext_int pulse → int_pend seen after 2 cycles, mcause_d=0x8000000B, priv_pc=0x802C.
  - ext_int with env_m in the same cycle → env_m wins, mcause_d=11, intr=0.
- mret: ret=1 with mepc_r=0x400 → next cycle insert_pc=1, priv_pc=0x400, mret_we=1 for exactly 1 cycle. ret and fault_s together → trap taken, mret_we never asserted.
- Masking and reset:
  - mstatus_mie=0 with timer_int=1 → no trap.
  - nRST asserted while in WAIT_CLEAR → all outputs 0 immediately; no insert_pc after release.

Source files
------------

// File: rtl/machine_mode_types_1_12_pkg.sv
// Machine-mode trap types shared by the trap sequencer and its priority encoder.
// Cause codes, mtvec mode constants and the trap FSM state encoding.
package machine_mode_types_1_12_pkg;

    typedef enum logic [4:0] {
        EX_INSN_MAL    = 5'd0,
        EX_INSN_FAULT  = 5'd1,
        EX_ILLEGAL     = 5'd2,
        EX_BREAKPOINT  = 5'd3,
        EX_LOAD_MAL    = 5'd4,
        EX_LOAD_FAULT  = 5'd5,
        EX_STORE_MAL   = 5'd6,
        EX_STORE_FAULT = 5'd7,
        EX_ECALL_M     = 5'd11,
        EX_RMGMT_BASE  = 5'd24
    } ex_code_t;

    typedef enum logic [4:0] {
        INT_SOFT  = 5'd3,
        INT_TIMER = 5'd7,
        INT_EXT   = 5'd11
    } int_code_t;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_CLEAR = 2'd1,
        COMMIT     = 2'd2,
        RET        = 2'd3
    } trap_state_t;

endpackage

// File: rtl/prv_trap_prio_enc.sv
// Combinational trap prioritiser: picks the winning cause code, flags interrupts,
// and says whether the faulting address belongs in mtval.
module prv_trap_prio_enc
    import machine_mode_types_1_12_pkg::*;
#(
    parameter int RMGMT_W = 1
) (
    input  logic               fault_insn,
    input  logic               mal_insn,
    input  logic               illegal_insn,
    input  logic               fault_l,
    input  logic               mal_l,
    input  logic               fault_s,
    input  logic               mal_s,
    input  logic               breakpoint,
    input  logic               env_m,
    input  logic               prot_fault_i,
    input  logic               prot_fault_l,
    input  logic               prot_fault_s,
    input  logic               ex_rmgmt,
    input  logic [RMGMT_W-1:0] ex_rmgmt_cause,
    input  logic               ext_pend,
    input  logic               soft_pend,
    input  logic               timer_pend,
    output logic [4:0]         code,
    output logic               is_int,
    output logic               tval_sel
);

    // Any exception outranks any interrupt; within each group the if-chain order is the priority.
    always_comb begin
        code     = 5'd0;
        is_int   = 1'b0;
        tval_sel = 1'b0;
        if (fault_insn | prot_fault_i) begin
            code     = EX_INSN_FAULT;
            tval_sel = 1'b1;
        end else if (illegal_insn) begin
            code = EX_ILLEGAL;
        end else if (mal_insn) begin
            code     = EX_INSN_MAL;
            tval_sel = 1'b1;
        end else if (env_m) begin
            code = EX_ECALL_M;
        end else if (breakpoint) begin
            code = EX_BREAKPOINT;
        end else if (mal_s) begin
            code     = EX_STORE_MAL;
            tval_sel = 1'b1;
        end else if (mal_l) begin
            code     = EX_LOAD_MAL;
            tval_sel = 1'b1;
        end else if (fault_s | prot_fault_s) begin
            code     = EX_STORE_FAULT;
            tval_sel = 1'b1;
        end else if (fault_l | prot_fault_l) begin
            code     = EX_LOAD_FAULT;
            tval_sel = 1'b1;
        end else if (ex_rmgmt) begin
            code = 5'(EX_RMGMT_BASE + 5'(ex_rmgmt_cause));
        end else if (ext_pend) begin
            code   = INT_EXT;
            is_int = 1'b1;
        end else if (soft_pend) begin
            code   = INT_SOFT;
            is_int = 1'b1;
        end else if (timer_pend) begin
            code   = INT_TIMER;
            is_int = 1'b1;
        end
    end

endmodule

// File: rtl/prv_trap_ctrl.sv
// Trap sequencer: captures the winning exception/interrupt, waits for the pipeline
// to drain, then issues a one-cycle redirect plus CSR strobes; also sequences mret.
module prv_trap_ctrl
    import machine_mode_types_1_12_pkg::*;
#(
    parameter  int NUM_EXTENSIONS = 1,
    parameter  int SYNC_STAGES    = 2,
    localparam int RMGMT_W        = (NUM_EXTENSIONS > 1) ? $clog2(NUM_EXTENSIONS) : 1
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               fault_insn,
    input  logic               mal_insn,
    input  logic               illegal_insn,
    input  logic               fault_l,
    input  logic               mal_l,
    input  logic               fault_s,
    input  logic               mal_s,
    input  logic               breakpoint,
    input  logic               env_m,
    input  logic               prot_fault_i,
    input  logic               prot_fault_l,
    input  logic               prot_fault_s,
    input  logic               ex_rmgmt,
    input  logic [RMGMT_W-1:0] ex_rmgmt_cause,
    input  logic [31:0]        epc,
    input  logic [31:0]        badaddr,
    input  logic               pipe_clear,
    input  logic               ret,
    input  logic               timer_int,
    input  logic               soft_int,
    input  logic               ext_int,
    input  logic               mstatus_mie,
    input  logic               mie_meie,
    input  logic               mie_msie,
    input  logic               mie_mtie,
    input  logic [31:0]        mtvec,
    input  logic [31:0]        mepc_r,
    output logic               insert_pc,
    output logic [31:0]        priv_pc,
    output logic               intr,
    output logic               csr_trap_we,
    output logic [31:0]        mcause_d,
    output logic [31:0]        mepc_d,
    output logic [31:0]        mtval_d,
    output logic               mret_we,
    output trap_state_t        state_dbg
);

    trap_state_t            state;
    logic [SYNC_STAGES-1:0] ext_sync;
    logic                   ext_s;
    logic                   exc_any;
    logic                   int_pend;
    logic                   ext_pend, soft_pend, timer_pend;
    logic [4:0]             enc_code;
    logic                   enc_is_int;
    logic                   enc_tval_sel;
    logic [4:0]             cap_code;
    logic                   cap_int;
    logic [31:0]            cap_epc;
    logic [31:0]            cap_tval;
    logic [31:0]            trap_base;
    logic [31:0]            trap_target;

    assign ext_s      = ext_sync[SYNC_STAGES-1];
    assign ext_pend   = mstatus_mie & ext_s & mie_meie;
    assign soft_pend  = mstatus_mie & soft_int & mie_msie;
    assign timer_pend = mstatus_mie & timer_int & mie_mtie;
    assign int_pend   = ext_pend | soft_pend | timer_pend;
    assign exc_any    = fault_insn | mal_insn | illegal_insn | fault_l | mal_l | fault_s
                      | mal_s | breakpoint | env_m | prot_fault_i | prot_fault_l
                      | prot_fault_s | ex_rmgmt;
    assign state_dbg  = state;

    // Only vectored mode with an interrupt offsets the base; reserved modes behave as direct.
    assign trap_base   = {mtvec[31:2], 2'b00};
    assign trap_target = (mtvec[1:0] == MTVEC_VECTORED && cap_int)
                       ? trap_base + {25'd0, cap_code, 2'b00}
                       : trap_base;

    prv_trap_prio_enc #(.RMGMT_W(RMGMT_W)) u_prio_enc (
        .fault_insn     (fault_insn),
        .mal_insn       (mal_insn),
        .illegal_insn   (illegal_insn),
        .fault_l        (fault_l),
        .mal_l          (mal_l),
        .fault_s        (fault_s),
        .mal_s          (mal_s),
        .breakpoint     (breakpoint),
        .env_m          (env_m),
        .prot_fault_i   (prot_fault_i),
        .prot_fault_l   (prot_fault_l),
        .prot_fault_s   (prot_fault_s),
        .ex_rmgmt       (ex_rmgmt),
        .ex_rmgmt_cause (ex_rmgmt_cause),
        .ext_pend       (ext_pend),
        .soft_pend      (soft_pend),
        .timer_pend     (timer_pend),
        .code           (enc_code),
        .is_int         (enc_is_int),
        .tval_sel       (enc_tval_sel)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ext_sync <= '0;
        end else begin
            ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_int};
        end
    end

    // Strobes are one-shot: they default low each cycle and are set only on entry to COMMIT/RET.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            cap_code    <= '0;
            cap_int     <= 1'b0;
            cap_epc     <= '0;
            cap_tval    <= '0;
            insert_pc   <= 1'b0;
            priv_pc     <= '0;
            intr        <= 1'b0;
            csr_trap_we <= 1'b0;
            mcause_d    <= '0;
            mepc_d      <= '0;
            mtval_d     <= '0;
            mret_we     <= 1'b0;
        end else begin
            insert_pc   <= 1'b0;
            priv_pc     <= '0;
            csr_trap_we <= 1'b0;
            mcause_d    <= '0;
            mepc_d      <= '0;
            mtval_d     <= '0;
            mret_we     <= 1'b0;
            case (state)
                IDLE: begin
                    if (exc_any | int_pend) begin
                        cap_code <= enc_code;
                        cap_int  <= enc_is_int;
                        cap_epc  <= epc;
                        cap_tval <= enc_tval_sel ? badaddr : 32'd0;
                        intr     <= enc_is_int;
                        state    <= WAIT_CLEAR;
                    end else if (ret) begin
                        insert_pc <= 1'b1;
                        priv_pc   <= mepc_r;
                        mret_we   <= 1'b1;
                        state     <= RET;
                    end
                end
                WAIT_CLEAR: begin
                    if (pipe_clear) begin
                        insert_pc   <= 1'b1;
                        priv_pc     <= trap_target;
                        csr_trap_we <= 1'b1;
                        mcause_d    <= {cap_int, 26'd0, cap_code};
                        mepc_d      <= cap_epc;
                        mtval_d     <= cap_tval;
                        state       <= COMMIT;
                    end
                end
                COMMIT: begin
                    intr  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
